// File: rtl/modulo_matriz_varredura.sv
// Column-multiplexed scan driver for a 5x7 LED matrix. The image is snapshotted once per frame.
// Optional anti-ghosting gap between columns: define MATRIZ_BLANK_EN.
module modulo_matriz_varredura #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [34:0] m_in,
    output logic [4:0]  col_n,
    output logic [6:0]  lin,
    output logic [2:0]  col_idx,
    output logic        frame_start
);

    // Out-of-range parameters are rejected when the design is elaborated.
    if ((DIV < 2) || (DIV > 65535) || (BLANK < 1) || (BLANK > 255)) begin : g_bad_param
        $error("modulo_matriz_varredura: DIV or BLANK out of range");
    end

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1
`ifdef MATRIZ_BLANK_EN
        ,
        ST_BLANK = 2'd2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  col_idx_q, col_idx_d;
    logic [34:0] shadow_q, shadow_d;
    logic        frame_start_q, frame_start_d;
`ifdef MATRIZ_BLANK_EN
    localparam logic [7:0] BLANK_LAST = 8'(BLANK - 1);
    logic [7:0]  blank_cnt_q, blank_cnt_d;
`endif

    // State and datapath registers; clr clears everything immediately.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'd0;
            col_idx_q     <= 3'd0;
            shadow_q      <= 35'd0;
            frame_start_q <= 1'b0;
`ifdef MATRIZ_BLANK_EN
            blank_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            col_idx_q     <= col_idx_d;
            shadow_q      <= shadow_d;
            frame_start_q <= frame_start_d;
`ifdef MATRIZ_BLANK_EN
            blank_cnt_q   <= blank_cnt_d;
`endif
        end
    end

    // Next-state logic: dwell counting, column advance and frame-boundary snapshot.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        col_idx_d     = col_idx_q;
        shadow_d      = shadow_q;
        frame_start_d = 1'b0;
`ifdef MATRIZ_BLANK_EN
        blank_cnt_d   = blank_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d       = ST_SCAN;
                    shadow_d      = m_in;
                    col_idx_d     = 3'd0;
                    cnt_d         = 16'd0;
                    frame_start_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = 16'd0;
`ifdef MATRIZ_BLANK_EN
                    // The last column only blanks when another frame follows.
                    if ((col_idx_q == 3'd4) && !en) begin
                        state_d   = ST_IDLE;
                        col_idx_d = 3'd0;
                    end else begin
                        state_d     = ST_BLANK;
                        blank_cnt_d = 8'd0;
                    end
`else
                    if (col_idx_q != 3'd4) begin
                        col_idx_d = col_idx_q + 3'd1;
                    end else if (en) begin
                        shadow_d      = m_in;
                        col_idx_d     = 3'd0;
                        frame_start_d = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        col_idx_d = 3'd0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef MATRIZ_BLANK_EN
            ST_BLANK: begin
                if (blank_cnt_q == BLANK_LAST) begin
                    state_d     = ST_SCAN;
                    blank_cnt_d = 8'd0;
                    if (col_idx_q != 3'd4) begin
                        col_idx_d = col_idx_q + 3'd1;
                    end else begin
                        shadow_d      = m_in;
                        col_idx_d     = 3'd0;
                        frame_start_d = 1'b1;
                    end
                end else begin
                    blank_cnt_d = blank_cnt_q + 8'd1;
                end
            end
`endif
            default: begin
                state_d   = ST_IDLE;
                col_idx_d = 3'd0;
                cnt_d     = 16'd0;
            end
        endcase
    end

    // Matrix drive decoded from registered state only, so m_in never reaches lin directly.
    always_comb begin
        col_n = 5'b11111;
        lin   = 7'd0;
        if (state_q == ST_SCAN) begin
            case (col_idx_q)
                3'd0: begin col_n = 5'b11110; lin = shadow_q[34:28]; end
                3'd1: begin col_n = 5'b11101; lin = shadow_q[27:21]; end
                3'd2: begin col_n = 5'b11011; lin = shadow_q[20:14]; end
                3'd3: begin col_n = 5'b10111; lin = shadow_q[13:7];  end
                3'd4: begin col_n = 5'b01111; lin = shadow_q[6:0];   end
                default: begin col_n = 5'b11111; lin = 7'd0; end
            endcase
        end else begin
            col_n = 5'b11111;
            lin   = 7'd0;
        end
    end

    assign col_idx     = col_idx_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_modulo_matriz_varredura.sv
// Scoreboard bench for modulo_matriz_varredura: expected per-cycle drive words are queued
// when stimulus is applied and popped one per clock.
module tb_modulo_matriz_varredura;

    localparam int DIV = 4;
`ifdef MATRIZ_BLANK_EN
    localparam int BLK = 2;
`else
    localparam int BLK = 0;
`endif
    localparam int CL = DIV + BLK;
    localparam int FL = 5 * CL;

    localparam logic [34:0] IMG1 = 35'h7F0000000;
    localparam logic [34:0] ONES = 35'h7FFFFFFFF;
    localparam logic [34:0] IMG4 = 35'h5A5A5A5A5;
    localparam logic [34:0] IMG5 = 35'h12468ACE1;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        en  = 1'b0;
    logic [34:0] m_in = 35'd0;
    logic [4:0]  col_n;
    logic [6:0]  lin;
    logic [2:0]  col_idx;
    logic        frame_start;

    logic [15:0] exp_q[$];
    int          fs_cyc[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;

    modulo_matriz_varredura #(.DIV(DIV), .BLANK(2)) dut (
        .clk(clk), .clr(clr), .en(en), .m_in(m_in),
        .col_n(col_n), .lin(lin), .col_idx(col_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] col_of(input logic [34:0] img, input int c);
        logic [34:0] t;
        t = img >> (7 * (4 - c));
        return t[6:0];
    endfunction

    function automatic logic [15:0] pack(input logic [4:0] cn, input logic [6:0] ln,
                                         input logic [2:0] ix, input logic fs);
        return {cn, ln, ix, fs};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(pack(5'b11111, 7'd0, 3'd0, 1'b0));
    endtask

    task automatic push_frame(input logic [34:0] img, input bit last_en);
        logic [4:0] m;
        for (int c = 0; c < 5; c++) begin
            m = 5'b00001 << c;
            for (int k = 0; k < DIV; k++)
                exp_q.push_back(pack(~m, col_of(img, c), 3'(c), (c == 0) && (k == 0)));
            if ((BLK > 0) && ((c < 4) || last_en))
                for (int k = 0; k < BLK; k++)
                    exp_q.push_back(pack(5'b11111, 7'd0, 3'(c), 1'b0));
        end
    endtask

    task automatic step();
        logic [15:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (frame_start === 1'b1) fs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty cycle=%0d observed=%h expected=none", cyc,
                   {col_n, lin, col_idx, frame_start});
        end else begin
            e = exp_q.pop_front();
            check("drive", {col_n, lin, col_idx, frame_start}, e);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_all();
        int guard;
        guard = 0;
        while ((exp_q.size() > 0) && (guard < 2000)) begin
            step();
            guard++;
        end
    endtask

    initial begin
        // Reset held with en high and a changing random image.
        clr  = 1'b1;
        en   = 1'b1;
        m_in = 35'({$urandom(), $urandom()});
        push_idle(3);
        for (int i = 0; i < 3; i++) begin
            step();
            m_in = 35'({$urandom(), $urandom()});
        end

        // Release with en low: the block must stay idle.
        en   = 1'b0;
        m_in = IMG1;
        clr  = 1'b0;
        push_idle(1);
        run(1);

        // Frames 1 and 2, with m_in changed during column 2 of frame 2.
        en = 1'b1;
        fs_cyc.delete();
        push_frame(IMG1, 1'b1);
        run_all();
        push_frame(IMG1, 1'b1);
        run(2 * CL);
        m_in = ONES;
        run_all();

        // Frame 3 shows the new image; en drops during column 1 and the frame still completes.
        push_frame(ONES, 1'b0);
        push_idle(3);
        run(CL);
        en = 1'b0;
        run_all();
        check("fs_count", 16'(fs_cyc.size()), 16'd3);
        check("fs_period12", 16'(fs_cyc[1] - fs_cyc[0]), 16'(FL));
        check("fs_period23", 16'(fs_cyc[2] - fs_cyc[1]), 16'(FL));

        // Re-raise en: column 0 carries the current image one cycle later.
        m_in = IMG4;
        en   = 1'b1;
        push_frame(IMG4, 1'b1);
        run_all();

        // Asynchronous clear in the middle of column 3.
        push_frame(IMG4, 1'b1);
        run(3 * CL + 2);
        exp_q.delete();
        #2;
        clr = 1'b1;
        #1;
        check("async_clr", {col_n, lin, col_idx, frame_start}, pack(5'b11111, 7'd0, 3'd0, 1'b0));
        push_idle(2);
        run(2);

        // Restart from idle with en high.
        m_in = IMG5;
        clr  = 1'b0;
        push_frame(IMG5, 1'b1);
        run_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
